// File: rtl/td4_core_gen.sv
// td4_core_gen: parametrised TD4 ISA core with run/single-step control; optional HLT opcode when TD4_HALT_EN is defined.
// Latency: one instruction per executing clk edge; every output is registered and shows the result one cycle later.
// Backpressure: none; execution is gated by run_i or a step_i rising edge and simply holds state when neither is present.
module td4_core_gen #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              step_i,
  input  logic [DATA_W+3:0] instr_i,
  input  logic [DATA_W-1:0] in_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] out_o,
  output logic [DATA_W-1:0] rega_o,
  output logic [DATA_W-1:0] regb_o,
  output logic              carry_o,
  output logic              halted_o
);

  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A  = 4'b0010;
  localparam logic [3:0] OP_MOV_A = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B  = 4'b0110;
  localparam logic [3:0] OP_MOV_B = 4'b0111;
`ifdef TD4_HALT_EN
  localparam logic [3:0] OP_HLT   = 4'b1000;
`endif
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  logic [DATA_W-1:0] imm;
  logic [3:0]        op;
  assign {imm, op} = instr_i;

  // Architectural state
  logic [PC_W-1:0]   pc_q, pc_n;
  logic [DATA_W-1:0] a_q, a_n;
  logic [DATA_W-1:0] b_q, b_n;
  logic [DATA_W-1:0] out_q, out_n;
  logic              c_q, c_n;
  logic              step_q;
  logic              step_rise;
  logic              halted;
  logic              exec;

  assign step_rise = step_i & ~step_q;
  // A simultaneous run and step rise still executes a single instruction.
  assign exec      = (run_i | step_rise) & ~halted;

  // Jump target: imm truncated or zero-extended to the PC width.
  logic [PC_W-1:0] tgt;
  generate
    if (PC_W > DATA_W) begin : g_tgt_ext
      assign tgt = {{(PC_W-DATA_W){1'b0}}, imm};
    end else begin : g_tgt_trunc
      assign tgt = imm[PC_W-1:0];
    end
  endgenerate

  // Adder source operand selected by opcode; MOV/OUT-immediate forms add to zero.
  logic [DATA_W-1:0] src;
  always_comb begin
    src = '0;
    case (op)
      OP_ADD_A, OP_MOV_BA:           src = a_q;
      OP_ADD_B, OP_MOV_AB, OP_OUT_B: src = b_q;
      OP_IN_A, OP_IN_B:              src = in_i;
      default:                       src = '0;
    endcase
  end

  logic [DATA_W:0] sum;
  assign sum = {1'b0, src} + {1'b0, imm};

`ifdef TD4_HALT_EN
  logic hlt_op;
`endif

  // Next-state decode for one executed instruction.
  always_comb begin
    a_n   = a_q;
    b_n   = b_q;
    out_n = out_q;
    c_n   = c_q;
    pc_n  = pc_q + PC_W'(1);
`ifdef TD4_HALT_EN
    hlt_op = 1'b0;
`endif
    case (op)
      OP_ADD_A, OP_MOV_A, OP_MOV_AB, OP_IN_A: begin
        a_n = sum[DATA_W-1:0];
        c_n = sum[DATA_W];
      end
      OP_ADD_B, OP_MOV_B, OP_MOV_BA, OP_IN_B: begin
        b_n = sum[DATA_W-1:0];
        c_n = sum[DATA_W];
      end
      OP_OUT_B, OP_OUT_I: begin
        out_n = sum[DATA_W-1:0];
        c_n   = sum[DATA_W];
      end
      OP_JMP: begin
        pc_n = tgt;
        c_n  = 1'b0;
      end
      OP_JNC: begin
        // Tests the carry held before this edge.
        if (!c_q) pc_n = tgt;
        c_n = 1'b0;
      end
`ifdef TD4_HALT_EN
      OP_HLT: begin
        // PC stays on the HLT so the halt location remains visible.
        pc_n   = pc_q;
        hlt_op = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Step edge detector tracks step_i every clock, halted or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step_i;
  end

  // Architectural registers update only on executing edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      c_q   <= 1'b0;
    end else if (exec) begin
      pc_q  <= pc_n;
      a_q   <= a_n;
      b_q   <= b_n;
      out_q <= out_n;
      c_q   <= c_n;
    end
  end

`ifdef TD4_HALT_EN
  logic halted_q;
  // Halt is sticky; only reset releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               halted_q <= 1'b0;
    else if (exec && hlt_op)  halted_q <= 1'b1;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign pc_o     = pc_q;
  assign out_o    = out_q;
  assign rega_o   = a_q;
  assign regb_o   = b_q;
  assign carry_o  = c_q;
  assign halted_o = halted;

endmodule
